// File: rtl/serializer_pkg.sv
// Shared types and helpers for the parametrised PISO serializer.
package serializer_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SHIFT  = 2'd1,
    PARITY = 2'd2
  } state_e;

  localparam logic DATA_OUT_IDLE = 1'b0;

  // Counter width able to hold values up to n (one spare bit of headroom).
  function automatic int cnt_width(input int n);
    return $clog2(n) + 1;
  endfunction

endpackage

// File: rtl/serializer_clk_div.sv
// Bit-rate divider: bit_tick fires on every CLK_DIV-th enabled cycle.
module serializer_clk_div
  import serializer_pkg::*;
#(
  parameter int CLK_DIV = 1
) (
  input  logic CLK,
  input  logic rst,
  input  logic en,
  input  logic clear,
  output logic bit_tick
);

  localparam int DIV_W = cnt_width(CLK_DIV);

  logic [DIV_W-1:0] div_cnt_q, div_cnt_d;

  always_comb begin
    bit_tick  = en && (div_cnt_q == DIV_W'(CLK_DIV - 1));
    div_cnt_d = div_cnt_q;
    if (clear || bit_tick) begin
      div_cnt_d = '0;
    end else if (en) begin
      div_cnt_d = div_cnt_q + DIV_W'(1);
    end
  end

  always_ff @(posedge CLK) begin
    if (rst) begin
      div_cnt_q <= '0;
    end else begin
      div_cnt_q <= div_cnt_d;
    end
  end

endmodule

// File: rtl/serializer_piso.sv
// Parallel-in/serial-out serializer with MSB/LSB ordering, send pause and sticky overrun.
// Optional trailing even-parity bit when SERIALIZER_PARITY_EN is defined.
module serializer_piso
  import serializer_pkg::*;
#(
  parameter int WIDTH     = 12,
  parameter int CLK_DIV   = 1,
  parameter int LSB_FIRST = 0
) (
  input  logic             CLK,
  input  logic             rst,
  input  logic             load,
  input  logic             send,
  input  logic [WIDTH-1:0] data_in,
  output logic             ready,
  output logic             busy,
  output logic             data_out,
  output logic             done,
  output logic             overrun,
  output logic [WIDTH-1:0] temp_data_out
);

  localparam int BIT_W = cnt_width(WIDTH);

  state_e           state_q, state_d;
  logic [WIDTH-1:0] shreg_q, shreg_d;
  logic [BIT_W-1:0] bit_cnt_q, bit_cnt_d;
  logic             done_q, done_d;
  logic             overrun_q, overrun_d;
  logic             bit_tick;
  logic             head_bit;
  logic             last_bit;
`ifdef SERIALIZER_PARITY_EN
  logic             parity_q, parity_d;
`endif

  assign ready         = (state_q == IDLE);
  assign busy          = ~ready;
  assign done          = done_q;
  assign overrun       = overrun_q;
  assign temp_data_out = shreg_q;

  serializer_clk_div #(
    .CLK_DIV (CLK_DIV)
  ) u_clk_div (
    .CLK      (CLK),
    .rst      (rst),
    .en       (send & busy),
    .clear    (ready),
    .bit_tick (bit_tick)
  );

  assign head_bit = (LSB_FIRST != 0) ? shreg_q[0] : shreg_q[WIDTH-1];
  assign last_bit = (bit_cnt_q == BIT_W'(WIDTH - 1));

  always_comb begin
    state_d   = state_q;
    shreg_d   = shreg_q;
    bit_cnt_d = bit_cnt_q;
    done_d    = 1'b0;
    overrun_d = overrun_q;
    data_out  = DATA_OUT_IDLE;
`ifdef SERIALIZER_PARITY_EN
    parity_d  = parity_q;
`endif
    case (state_q)
      IDLE: begin
        if (load) begin
          shreg_d   = data_in;
          bit_cnt_d = '0;
          state_d   = SHIFT;
`ifdef SERIALIZER_PARITY_EN
          parity_d  = ^data_in;
`endif
        end
      end
      SHIFT: begin
        data_out = head_bit;
        if (load) overrun_d = 1'b1;
        if (bit_tick) begin
          // Zero-fill so the register reads all-zero once the word is out.
          shreg_d   = (LSB_FIRST != 0) ? (shreg_q >> 1) : (shreg_q << 1);
          bit_cnt_d = bit_cnt_q + BIT_W'(1);
          if (last_bit) begin
            bit_cnt_d = '0;
`ifdef SERIALIZER_PARITY_EN
            state_d   = PARITY;
`else
            state_d   = IDLE;
            done_d    = 1'b1;
`endif
          end
        end
      end
`ifdef SERIALIZER_PARITY_EN
      PARITY: begin
        data_out = parity_q;
        if (load) overrun_d = 1'b1;
        if (bit_tick) begin
          state_d = IDLE;
          done_d  = 1'b1;
        end
      end
`endif
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (rst) begin
      state_q   <= IDLE;
      shreg_q   <= '0;
      bit_cnt_q <= '0;
      done_q    <= 1'b0;
      overrun_q <= 1'b0;
`ifdef SERIALIZER_PARITY_EN
      parity_q  <= 1'b0;
`endif
    end else begin
      state_q   <= state_d;
      shreg_q   <= shreg_d;
      bit_cnt_q <= bit_cnt_d;
      done_q    <= done_d;
      overrun_q <= overrun_d;
`ifdef SERIALIZER_PARITY_EN
      parity_q  <= parity_d;
`endif
    end
  end

endmodule
